// File: rtl/rs_pkg.sv
// Shared constants for the RS(76,64) encoder scheduler.
//   RS_K_SYM / RS_N_SYM / RS_SYM_W : code geometry in symbols and symbol width
//   RS_K_BITS / RS_N_BITS          : derived data and codeword widths
//   state_t                        : scheduler FSM states
package rs_pkg;

    localparam int unsigned RS_K_SYM  = 64;
    localparam int unsigned RS_N_SYM  = 76;
    localparam int unsigned RS_SYM_W  = 8;
    localparam int unsigned RS_K_BITS = RS_K_SYM * RS_SYM_W;
    localparam int unsigned RS_N_BITS = RS_N_SYM * RS_SYM_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_RESP    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req       : request vector
//   ptr       : index with highest priority this cycle
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted requester (0 when no request)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    // Walk the search order from the far end back toward ptr so the
    // last hit written is the first requester at or after ptr.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (req[(32'(ptr) + (NUM_REQ - 1 - k)) % NUM_REQ]) begin
                grant     = NUM_REQ'(1) << ((32'(ptr) + (NUM_REQ - 1 - k)) % NUM_REQ);
                grant_idx = ID_W'((32'(ptr) + (NUM_REQ - 1 - k)) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/rs_enc_scheduler.sv
// Shares one RS(76,64) encoder between NUM_REQ requesters.
//   req_valid/req_data/req_ready : per-requester job input, one-hot accept
//   rsp_valid/rsp_ready          : response handshake carrying rsp_id,
//                                  rsp_code and rsp_err (timeout, code 0)
//   enc_start/enc_data           : level start and held data to the encoder
//   enc_code/enc_valid           : encoder result
//   clear_fault                  : pulse that leaves FAULT
//   busy/fault/err_cnt           : status; err_cnt saturates at 255
module rs_enc_scheduler
    import rs_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned K_BITS      = RS_K_BITS,
    parameter int unsigned N_BITS      = RS_N_BITS,
    parameter int unsigned ENC_TIMEOUT = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*K_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [N_BITS-1:0]         rsp_code,
    output logic                      rsp_err,
    output logic                      enc_start,
    output logic [K_BITS-1:0]         enc_data,
    input  logic [N_BITS-1:0]         enc_code,
    input  logic                      enc_valid,
    input  logic                      clear_fault,
    output logic                      busy,
    output logic                      fault,
    output logic [7:0]                err_cnt
);

    localparam int unsigned TMR_W = $clog2(ENC_TIMEOUT) + 1;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [ID_W-1:0]    ptr;
    logic               fault_pending;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Gated by rst_n so no accept is offered while reset is held.
    assign req_ready = (rst_n && state == ST_IDLE) ? grant : '0;
    assign busy      = (state != ST_IDLE);
    assign fault     = (state == ST_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            timer         <= '0;
            ptr           <= '0;
            fault_pending <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_code      <= '0;
            rsp_err       <= 1'b0;
            enc_start     <= 1'b0;
            enc_data      <= '0;
            err_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        enc_data  <= req_data[32'(grant_idx) * K_BITS +: K_BITS];
                        rsp_id    <= grant_idx;
                        ptr       <= ID_W'((32'(grant_idx) + 1) % NUM_REQ);
                        timer     <= '0;
                        enc_start <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    timer <= timer + TMR_W'(1);
                    // A result arriving on the last allowed cycle still counts.
                    if (enc_valid) begin
                        rsp_code  <= enc_code;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (timer == TMR_W'(ENC_TIMEOUT - 1)) begin
                        rsp_code      <= '0;
                        rsp_err       <= 1'b1;
                        rsp_valid     <= 1'b1;
                        fault_pending <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // enc_start stays high here so the encoder holds its result.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        enc_start <= 1'b0;
                        state     <= fault_pending ? ST_FAULT : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                ST_FAULT: begin
                    if (clear_fault) begin
                        fault_pending <= 1'b0;
                        state         <= ST_RELEASE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_enc_scheduler.sv
// Self-checking bench for rs_enc_scheduler with a latency-programmable
// encoder model. Table-driven jobs plus hand-written multi-cycle sequences.
module tb_rs_enc_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int K_BITS  = 512;
    localparam int N_BITS  = 608;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*K_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [N_BITS-1:0]         rsp_code;
    logic                      rsp_err;
    logic                      enc_start;
    logic [K_BITS-1:0]         enc_data;
    logic [N_BITS-1:0]         enc_code;
    logic                      enc_valid;
    logic                      clear_fault;
    logic                      busy;
    logic                      fault;
    logic [7:0]                err_cnt;

    int tests = 0;
    int fails = 0;
    int enc_lat = 1000;
    int enc_cnt = 0;

    always #5 clk = ~clk;

    rs_enc_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .ID_W        (ID_W),
        .K_BITS      (K_BITS),
        .N_BITS      (N_BITS),
        .ENC_TIMEOUT (128)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_code    (rsp_code),
        .rsp_err     (rsp_err),
        .enc_start   (enc_start),
        .enc_data    (enc_data),
        .enc_code    (enc_code),
        .enc_valid   (enc_valid),
        .clear_fault (clear_fault),
        .busy        (busy),
        .fault       (fault),
        .err_cnt     (err_cnt)
    );

    function automatic logic [K_BITS-1:0] pat(input int i);
        logic [7:0] b;
        b = 8'hA5 + 8'(i * 60);
        return {64{b}};
    endfunction

    function automatic logic [N_BITS-1:0] code_of(input logic [K_BITS-1:0] d);
        logic [95:0] par;
        par = d[95:0] ^ 96'h0123456789ABCDEF01234567;
        return {par, d};
    endfunction

    function automatic int idx_of(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Encoder model: valid rises enc_lat cycles after the first start cycle.
    always_ff @(posedge clk) begin
        if (!enc_start) enc_cnt <= 0;
        else if (enc_cnt < 100000) enc_cnt <= enc_cnt + 1;
    end
    assign enc_valid = enc_start && (enc_cnt >= enc_lat);
    assign enc_code  = code_of(enc_data);

    task automatic chk(input string name, input logic [N_BITS-1:0] act, input logic [N_BITS-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NUM_REQ-1:0] mask;
        int                 lat;
        int                 hold;
        int                 exp_id;
        bit                 exp_err;
        int                 exp_lat;
        int                 exp_errcnt;
    } job_t;

    job_t jobs[8];

    task automatic run_job(input job_t j);
        int n;
        int id;
        int bad;
        bit got;
        logic [N_BITS-1:0] exp_code;
        req_valid = j.mask;
        enc_lat   = j.lat;
        rsp_ready = 1'b0;
        got = 1'b0;
        id  = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (req_ready != '0) begin
                got = 1'b1;
                id  = idx_of(req_ready);
                chk("grant_onehot", 608'($onehot(req_ready)), 608'd1);
            end
            step();
        end
        req_valid = '0;
        chk("grant_seen", 608'(got), 608'd1);
        chk("grant_id", 608'(id), 608'(j.exp_id));
        chk("enc_start_t1", 608'(enc_start), 608'd1);
        chk("enc_data", 608'(enc_data), 608'(pat(j.exp_id)));
        n = 1;
        while (!rsp_valid && n < 400) begin
            step();
            n++;
        end
        chk("rsp_latency", 608'(n), 608'(j.exp_lat));
        exp_code = j.exp_err ? '0 : code_of(pat(j.exp_id));
        bad = 0;
        req_valid = '1;
        for (int h = 0; h < j.hold; h++) begin
            #1;
            if (!rsp_valid || !enc_start || req_ready != '0 ||
                rsp_id != ID_W'(j.exp_id) || rsp_code !== exp_code) bad++;
            step();
        end
        req_valid = '0;
        if (j.hold > 0) chk("resp_hold_stable", 608'(bad), 608'd0);
        chk("rsp_id", 608'(rsp_id), 608'(j.exp_id));
        chk("rsp_err", 608'(rsp_err), 608'(j.exp_err));
        chk("rsp_code", rsp_code, exp_code);
        chk("err_cnt", 608'(err_cnt), 608'(j.exp_errcnt));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 608'(rsp_valid), 608'd0);
        chk("enc_start_low", 608'(enc_start), 608'd0);
        if (j.exp_err) begin
            chk("fault_set", 608'(fault), 608'd1);
        end else begin
            chk("release_state", 608'({busy, fault}), 608'd2);
            step();
            chk("back_to_idle", 608'(busy), 608'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int grants[5];
        int ng;
        int cur;
        int bad_oh;
        int bad_data;
        int bad;
        int n;

        jobs[0] = '{4'b0001,   66,  0, 0, 1'b0,  68, 0};
        jobs[1] = '{4'b1111,    3,  0, 1, 1'b0,   5, 0};
        jobs[2] = '{4'b0001,    0,  0, 0, 1'b0,   2, 0};
        jobs[3] = '{4'b1010,    5, 20, 1, 1'b0,   7, 0};
        jobs[4] = '{4'b1010,    1,  0, 3, 1'b0,   3, 0};
        jobs[5] = '{4'b1100,  127,  0, 2, 1'b0, 129, 0};
        jobs[6] = '{4'b0111,   10,  0, 0, 1'b0,  12, 0};
        jobs[7] = '{4'b0100, 1000,  0, 2, 1'b1, 129, 1};

        for (int i = 0; i < NUM_REQ; i++) req_data[i*K_BITS +: K_BITS] = pat(i);
        rst_n       = 1'b0;
        req_valid   = '1;
        rsp_ready   = 1'b0;
        clear_fault = 1'b0;
        step();
        step();
        chk("reset_ctrl", 608'({req_ready, rsp_valid, rsp_id, rsp_err, enc_start, busy, fault, err_cnt}), 608'd0);
        chk("reset_code", rsp_code, '0);
        chk("reset_enc_data", 608'(enc_data), 608'd0);
        req_valid = '0;
        rst_n = 1'b1;
        step();

        // All four requesting continuously.
        req_valid = '1;
        enc_lat   = 2;
        rsp_ready = 1'b1;
        ng = 0; cur = -1; bad_oh = 0; bad_data = 0;
        for (int c = 0; c < 200 && !(ng >= 5 && !busy); c++) begin
            #1;
            if (!$onehot0(req_ready)) bad_oh++;
            if (busy && cur >= 0 && enc_data !== pat(cur)) bad_data++;
            if (req_ready != '0) begin
                cur = idx_of(req_ready);
                if (ng < 5) grants[ng] = cur;
                ng++;
            end
            step();
            if (ng >= 5) req_valid = '0;
        end
        rsp_ready = 1'b0;
        chk("rr_grant_count", 608'(ng), 608'd5);
        for (int i = 0; i < 5; i++) chk("rr_order", 608'(grants[i]), 608'(i % 4));
        chk("rr_onehot", 608'(bad_oh), 608'd0);
        chk("rr_enc_data_held", 608'(bad_data), 608'd0);

        for (int i = 0; i < 8; i++) run_job(jobs[i]);

        // In FAULT: requests ignored until clear_fault.
        bad = 0;
        req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (req_ready != '0 || !fault) bad++;
            step();
        end
        chk("fault_blocks_req", 608'(bad), 608'd0);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        n = 1;
        while (n < 10) begin
            #1;
            if (req_ready != '0) break;
            step();
            n++;
        end
        chk("clear_to_grant", 608'(n), 608'd2);
        chk("grant_after_fault", 608'(idx_of(req_ready)), 608'd3);
        enc_lat = 1000;
        step();
        req_valid = '0;

        // Reset during RUN cycle 30.
        repeat (29) step();
        chk("run_before_reset", 608'({busy, enc_start}), 608'd3);
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_ctrl", 608'({req_ready, rsp_valid, rsp_id, rsp_err, enc_start, busy, fault, err_cnt}), 608'd0);
        chk("midrun_reset_data", 608'(enc_data), 608'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("ptr_after_reset", 608'(req_ready), 608'd1);
        step();
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs_enc_scheduler.md
Name: rs_enc_scheduler

Overview:
Shares one RS(76,64) encoder instance (512-bit data in, 608-bit codeword out, start/valid_out level handshake) between NUM_REQ requesters. Arbitration is round-robin. The block latches the winning data and holds it stable on the encoder for the whole job. It sequences the encoder's start level, captures the codeword and returns it with the requester ID over a valid/ready response channel. A watchdog guards against an encoder that never raises valid_out.

Parameters:
NUM_REQ, 4, number of requesters
ID_W, 2, requester ID width (clog2 NUM_REQ)
K_BITS, 512, data bits per job (64 symbols x 8)
N_BITS, 608, codeword bits (76 symbols x 8)
ENC_TIMEOUT, 128, max cycles in RUN waiting for enc_valid

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester job request
req_data  in  NUM_REQ*K_BITS  flat data; requester i at [i*K_BITS +: K_BITS]
req_ready  out  NUM_REQ  one-hot accept
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  requester served
rsp_code  out  N_BITS  captured codeword
rsp_err  out  1  job timed out; rsp_code is 0
enc_start  out  1  encoder start level
enc_data  out  K_BITS  encoder data_in, registered
enc_code  in  N_BITS  encoder code_out
enc_valid  in  1  encoder valid_out
clear_fault  in  1  single-cycle pulse that leaves FAULT
busy  out  1  state != IDLE
fault  out  1  state == FAULT
err_cnt  out  8  timeouts, saturating at 255

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low on rst_n.
- Reset values: state IDLE, rr pointer 0, and every output/register 0 (enc_start, enc_data, rsp_*, req_ready, err_cnt, counters). Reset mid-job drops the job with no response.
- States: IDLE, RUN, RESP, RELEASE, FAULT.
- IDLE, arbitration:
  - Search starts at the rr pointer and takes the first i with req_valid[i] high.
  - req_ready[i] = (state==IDLE) & grant[i], combinational, at most one bit high.
  - On accept: enc_data <= req_data slice, id <= i, pointer <= (i+1) mod NUM_REQ, timer <= 0, go to RUN.
  - With no valid requests, stay in IDLE and leave the pointer unchanged.
- RUN:
  - enc_start = 1 and timer increments each cycle.
  - enc_valid high: rsp_code <= enc_code, rsp_err <= 0, go to RESP.
  - Otherwise, timer == ENC_TIMEOUT-1: rsp_code <= 0, rsp_err <= 1, err_cnt++ (saturating), go to RESP with fault_pending set.
  - enc_valid wins over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid = 1 and enc_start stays 1, so the encoder holds DONE.
  - rsp_id, rsp_code and rsp_err stay stable until rsp_valid & rsp_ready.
  - On handshake: go to RELEASE, or to FAULT if fault_pending.
- RELEASE:
  - Exactly 1 cycle with enc_start = 0, so the encoder returns to IDLE and clears its parity.
  - Then IDLE. A back-to-back grant is legal on the next cycle.
- FAULT:
  - enc_start = 0 and req_ready = 0.
  - clear_fault clears fault_pending and goes to RELEASE.
  - clear_fault outside FAULT is ignored.
- enc_data changes only on acceptance, so it is stable from accept through RELEASE.
- Nominal encoder contract: enc_valid rises within 66 cycles of enc_start rising.
- Latency, request accepted at cycle t:
  - enc_start high from t+1.
  - rsp_valid at t+2+L, where L is the number of encoder cycles to valid.
  - Minimum turnaround between jobs: RESP handshake, then 1 RELEASE cycle, then IDLE accept.

Decomposition:
- Shared package rs_pkg holds RS_K_SYM=64, RS_N_SYM=76, RS_SYM_W=8, the derived K_BITS/N_BITS and the state encoding constants.
- Sub-module rr_arbiter (NUM_REQ; inputs req, ptr; outputs grant one-hot, grant_idx) implements the combinational round-robin pick.
- Watchdog and FSM stay in rs_enc_scheduler.

Test Plan:
- Single request, encoder model with L=66:
  - Stimulus: req_valid=4'b0001, req_data[511:0]=all 0xA5, rsp_ready=1.
  - Response: req_ready[0] at t; rsp_valid at t+68 with rsp_id=0, rsp_err=0, rsp_code matching the model; enc_start low for exactly 1 cycle after the handshake.
- All four requesting continuously:
  - Response: grants in order 0,1,2,3,0; enc_data equals each requester's pattern throughout its job; no two req_ready bits high together.
- rsp_ready held low 20 cycles in RESP:
  - Response: rsp_* stable, enc_start stays 1, no req_ready.
  - On release: RELEASE for 1 cycle, then next grant.
- Encoder model never raises valid:
  - Response: rsp_valid at t+1+128 with rsp_err=1, rsp_code=0, err_cnt=1; fault=1 after the handshake.
  - Requests are ignored until a clear_fault pulse, then the next grant occurs 2 cycles later.
- enc_valid and timeout in the same cycle:
  - Response: rsp_err=0, err_cnt unchanged, no FAULT.
- rst_n asserted mid-RUN (cycle 30):
  - Response: all outputs 0 immediately; after release, the pointer restarts at requester 0.
